rename_stage: RTL and testbench

- 2-wide register rename stage, directly downstream of decode_stage (one decode_stage instance per slot).
- Maps architectural rd/rs1/rs2 (5b) of both slots onto physical registers (NUM_P_REGS=64). Uses a register alias table (RAT) and a circular free list.
- Produces a registered renamed bundle for dispatch.
- Accepts up to 2 physical-register frees per cycle from retire.

---
 rtl/riscv_pkg.sv | 11 +
 rtl/rename_stage_free_list.sv | 47 ++++
 rtl/rename_stage.sv | 110 +++++++++++
 tb/tb_rename_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: register-file sizing and index types shared by the rename slice.
package riscv_pkg;
    localparam int NUM_A_REGS = 32;
    localparam int NUM_P_REGS = 64;
    localparam int AREG_W = $clog2(NUM_A_REGS);
    localparam int PREG_W = $clog2(NUM_P_REGS);
    localparam int FL_DEPTH = NUM_P_REGS - NUM_A_REGS;
    localparam int FL_W = $clog2(FL_DEPTH);
    typedef logic [AREG_W-1:0] areg_t;
    typedef logic [PREG_W-1:0] preg_t;
endpackage

// File: rtl/rename_stage_free_list.sv
// free_list: circular preg FIFO with up to 2 pops and 2 pushes per cycle.
module free_list
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        pops,
    input  logic              push0,
    input  logic              push1,
    input  logic [PREG_W-1:0] preg0,
    input  logic [PREG_W-1:0] preg1,
    output logic [PREG_W-1:0] head0,
    output logic [PREG_W-1:0] head1,
    output logic [PREG_W-1:0] count
);
    preg_t           mem [FL_DEPTH];
    logic [FL_W-1:0] head;
    logic [FL_W-1:0] tail;
    logic            v0;
    logic            v1;

    // preg 0 is the hardwired x0 mapping and must never re-enter the pool
    assign v0 = push0 && preg0 != '0;
    assign v1 = push1 && preg1 != '0;
    assign head0 = mem[head];
    assign head1 = mem[head + FL_W'(1)];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) mem[i] <= PREG_W'(FL_DEPTH + i);
            head  <= '0;
            tail  <= '0;
            count <= PREG_W'(FL_DEPTH);
        end else begin
            if (v0) mem[tail] <= preg0;
            if (v1) mem[tail + FL_W'(v0)] <= preg1;
            head  <= head + FL_W'(pops);
            tail  <= tail + FL_W'(v0) + FL_W'(v1);
            count <= count - PREG_W'(pops) + PREG_W'(v0) + PREG_W'(v1);
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        (7'(count) + 7'(v0) + 7'(v1)) <= 7'(FL_DEPTH));
    no_underflow: assert property (@(posedge clk) disable iff (rst)
        7'(pops) <= 7'(count));
endmodule

// File: rtl/rename_stage.sv
// rename_stage: 2-wide RAT rename with intra-bundle bypass and a registered output bundle.
module rename_stage
    import riscv_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              wen0_i,
    input  logic              wen1_i,
    input  logic [AREG_W-1:0] rd0_i,
    input  logic [AREG_W-1:0] rs10_i,
    input  logic [AREG_W-1:0] rs20_i,
    input  logic [AREG_W-1:0] rd1_i,
    input  logic [AREG_W-1:0] rs11_i,
    input  logic [AREG_W-1:0] rs21_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [PREG_W-1:0] prd0_o,
    output logic [PREG_W-1:0] prs10_o,
    output logic [PREG_W-1:0] prs20_o,
    output logic [PREG_W-1:0] old_prd0_o,
    output logic [PREG_W-1:0] prd1_o,
    output logic [PREG_W-1:0] prs11_o,
    output logic [PREG_W-1:0] prs21_o,
    output logic [PREG_W-1:0] old_prd1_o,
    input  logic              free0_i,
    input  logic              free1_i,
    input  logic [PREG_W-1:0] free_preg0_i,
    input  logic [PREG_W-1:0] free_preg1_i
);
    preg_t             rat [NUM_A_REGS];
    logic [PREG_W-1:0] fl_head0;
    logic [PREG_W-1:0] fl_head1;
    logic [PREG_W-1:0] fl_count;
    logic              accept;
    logic              alloc0;
    logic              alloc1;
    logic              dup_rd;
    logic [1:0]        pops;
    preg_t             prd0;
    preg_t             prd1;
    preg_t             prs10;
    preg_t             prs20;
    preg_t             prs11;
    preg_t             prs21;
    preg_t             old0;
    preg_t             old1;

    free_list u_free_list (
        .clk   (clk_i),
        .rst   (rst_i),
        .pops  (pops),
        .push0 (free0_i),
        .push1 (free1_i),
        .preg0 (free_preg0_i),
        .preg1 (free_preg1_i),
        .head0 (fl_head0),
        .head1 (fl_head1),
        .count (fl_count)
    );

    assign ready_o = (fl_count >= PREG_W'(2)) && (!valid_o || ready_i);
    assign accept  = valid_i && ready_o;
    assign alloc0  = wen0_i && rd0_i != '0;
    assign alloc1  = wen1_i && rd1_i != '0;
    assign dup_rd  = alloc0 && rd1_i == rd0_i;
    assign pops    = accept ? {1'b0, alloc0} + {1'b0, alloc1} : 2'd0;

    // slot 1 sees slot 0 as if it had already renamed; slot 0 never sees slot 1
    always_comb begin
        prd0  = alloc0 ? fl_head0 : '0;
        prd1  = alloc1 ? (alloc0 ? fl_head1 : fl_head0) : '0;
        prs10 = rs10_i == '0 ? '0 : rat[rs10_i];
        prs20 = rs20_i == '0 ? '0 : rat[rs20_i];
        prs11 = rs11_i == '0 ? '0 : (alloc0 && rs11_i == rd0_i) ? prd0 : rat[rs11_i];
        prs21 = rs21_i == '0 ? '0 : (alloc0 && rs21_i == rd0_i) ? prd0 : rat[rs21_i];
        old0  = alloc0 ? rat[rd0_i] : '0;
        old1  = alloc1 ? (dup_rd ? prd0 : rat[rd1_i]) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_A_REGS; i++) rat[i] <= PREG_W'(i);
            valid_o    <= 1'b0;
            prd0_o     <= '0;
            prs10_o    <= '0;
            prs20_o    <= '0;
            old_prd0_o <= '0;
            prd1_o     <= '0;
            prs11_o    <= '0;
            prs21_o    <= '0;
            old_prd1_o <= '0;
        end else if (accept) begin
            if (alloc0) rat[rd0_i] <= prd0;
            if (alloc1) rat[rd1_i] <= prd1;
            valid_o    <= 1'b1;
            prd0_o     <= prd0;
            prs10_o    <= prs10;
            prs20_o    <= prs20;
            old_prd0_o <= old0;
            prd1_o     <= prd1;
            prs11_o    <= prs11;
            prs21_o    <= prs21;
            old_prd1_o <= old1;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: directed and randomized checks of rename_stage against a sequential-rename model.
module tb_rename_stage;
    import riscv_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i, valid_i, ready_o, wen0_i, wen1_i, valid_o, ready_i, free0_i, free1_i;
    logic [4:0] rd0_i, rs10_i, rs20_i, rd1_i, rs11_i, rs21_i;
    logic [5:0] prd0_o, prs10_o, prs20_o, old_prd0_o, prd1_o, prs11_o, prs21_o, old_prd1_o;
    logic [5:0] free_preg0_i, free_preg1_i;

    rename_stage dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .wen0_i(wen0_i), .wen1_i(wen1_i),
        .rd0_i(rd0_i), .rs10_i(rs10_i), .rs20_i(rs20_i),
        .rd1_i(rd1_i), .rs11_i(rs11_i), .rs21_i(rs21_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .prd0_o(prd0_o), .prs10_o(prs10_o), .prs20_o(prs20_o), .old_prd0_o(old_prd0_o),
        .prd1_o(prd1_o), .prs11_o(prs11_o), .prs21_o(prs21_o), .old_prd1_o(old_prd1_o),
        .free0_i(free0_i), .free1_i(free1_i),
        .free_preg0_i(free_preg0_i), .free_preg1_i(free_preg1_i)
    );

    int checks = 0;
    int errors = 0;
    int rat[32];
    int fl[$];
    int pool[$];
    bit mvalid;
    int e_prd0, e_prs10, e_prs20, e_old0, e_prd1, e_prs11, e_prs21, e_old1;

    task automatic chk(string tag, logic [7:0] obs, int exp);
        checks++;
        assert (obs === 8'(exp)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int a = 0; a < 32; a++) rat[a] = a;
        fl.delete();
        for (int i = 0; i < 32; i++) fl.push_back(32 + i);
        pool.delete();
        mvalid = 0;
        {e_prd0, e_prs10, e_prs20, e_old0, e_prd1, e_prs11, e_prs21, e_old1} = '0;
    endtask

    task automatic bun(bit v, bit w0, int d0, int s10, int s20, bit w1, int d1, int s11, int s21);
        valid_i = v; wen0_i = w0; wen1_i = w1;
        rd0_i = 5'(d0); rs10_i = 5'(s10); rs20_i = 5'(s20);
        rd1_i = 5'(d1); rs11_i = 5'(s11); rs21_i = 5'(s21);
    endtask

    // slots are renamed one after the other against a live map, which is what bypass means
    task automatic step();
        bit mready;
        int o;
        #2;
        mready = fl.size() >= 2 && (!mvalid || ready_i);
        if (!rst_i) chk("ready", ready_o, int'(mready));
        if (rst_i) mreset();
        else begin
            if (valid_i && mready) begin
                e_prs10 = rat[rs10_i]; e_prs20 = rat[rs20_i];
                e_prd0 = 0; e_old0 = 0; e_prd1 = 0; e_old1 = 0;
                if (wen0_i && rd0_i != 0) begin
                    e_prd0 = fl.pop_front(); o = rat[rd0_i]; e_old0 = o;
                    rat[rd0_i] = e_prd0; pool.push_back(o);
                end
                e_prs11 = rat[rs11_i]; e_prs21 = rat[rs21_i];
                if (wen1_i && rd1_i != 0) begin
                    e_prd1 = fl.pop_front(); o = rat[rd1_i]; e_old1 = o;
                    rat[rd1_i] = e_prd1; pool.push_back(o);
                end
                mvalid = 1;
            end else if (ready_i) mvalid = 0;
            if (free0_i && free_preg0_i != 0) fl.push_back(int'(free_preg0_i));
            if (free1_i && free_preg1_i != 0) fl.push_back(int'(free_preg1_i));
        end
        @(posedge clk);
        #1;
        chk("valid_o", valid_o, int'(mvalid));
        if (mvalid) begin
            chk("prd0", prd0_o, e_prd0); chk("prs10", prs10_o, e_prs10);
            chk("prs20", prs20_o, e_prs20); chk("old_prd0", old_prd0_o, e_old0);
            chk("prd1", prd1_o, e_prd1); chk("prs11", prs11_o, e_prs11);
            chk("prs21", prs21_o, e_prs21); chk("old_prd1", old_prd1_o, e_old1);
        end
    endtask

    task automatic do_reset();
        rst_i = 1; valid_i = 0; free0_i = 0; free1_i = 0; ready_i = 1;
        step();
        rst_i = 0;
    endtask

    initial begin
        bun(0, 0, 0, 0, 0, 0, 0, 0, 0);
        free_preg0_i = 0; free_preg1_i = 0;
        do_reset();
        chk("rst_valid", valid_o, 0); chk("rst_prd0", prd0_o, 0);
        chk("rst_old_prd1", old_prd1_o, 0); chk("rst_ready", ready_o, 1);

        bun(1, 1, 5, 1, 2, 1, 6, 5, 3);
        step();
        chk("dep_valid", valid_o, 1); chk("dep_prd0", prd0_o, 32);
        chk("dep_prs10", prs10_o, 1); chk("dep_prs20", prs20_o, 2);
        chk("dep_old0", old_prd0_o, 5); chk("dep_prd1", prd1_o, 33);
        chk("dep_prs11", prs11_o, 32); chk("dep_prs21", prs21_o, 3);
        chk("dep_old1", old_prd1_o, 6);

        do_reset();
        bun(1, 1, 7, 0, 0, 1, 7, 0, 0);
        step();
        chk("same_prd0", prd0_o, 32); chk("same_old0", old_prd0_o, 7);
        chk("same_prd1", prd1_o, 33); chk("same_old1", old_prd1_o, 32);
        bun(1, 0, 0, 7, 0, 0, 0, 7, 7);
        step();
        chk("same_rd_prs10", prs10_o, 33); chk("same_rd_prs11", prs11_o, 33);
        chk("same_rd_prs21", prs21_o, 33); chk("same_rd_prd0", prd0_o, 0);

        do_reset();
        bun(1, 1, 0, 1, 2, 0, 4, 3, 4);
        step();
        chk("x0_prd0", prd0_o, 0); chk("x0_prd1", prd1_o, 0);
        chk("x0_old0", old_prd0_o, 0); chk("x0_old1", old_prd1_o, 0);
        bun(1, 0, 0, 0, 0, 1, 9, 0, 0);
        step();
        chk("x0_next_prd1", prd1_o, 32);

        do_reset();
        bun(1, 1, 5, 1, 2, 1, 6, 3, 4);
        step();
        for (int k = 1; k < 16; k++) begin
            bun(1, 1, k + 1, k, 0, 1, k + 16, 0, k);
            step();
        end
        valid_i = 0;
        chk("exh_ready", ready_o, 0);
        free0_i = 1; free_preg0_i = 5; free1_i = 1; free_preg1_i = 6;
        step();
        free0_i = 0; free1_i = 0;
        chk("refill_ready", ready_o, 1);
        bun(1, 1, 10, 0, 0, 1, 11, 0, 0);
        step();
        chk("refill_prd0", prd0_o, 5); chk("refill_prd1", prd1_o, 6);

        do_reset();
        bun(1, 1, 5, 1, 2, 1, 6, 5, 3);
        step();
        ready_i = 0;
        bun(1, 1, 12, 0, 0, 1, 13, 0, 0);
        repeat (3) begin
            step();
            chk("bp_valid", valid_o, 1); chk("bp_prd0", prd0_o, 32);
            chk("bp_prd1", prd1_o, 33); chk("bp_prs11", prs11_o, 32);
            chk("bp_ready", ready_o, 0);
        end
        ready_i = 1; valid_i = 0;
        step();
        chk("bp_drain", valid_o, 0);
        bun(1, 1, 9, 0, 0, 0, 0, 0, 0);
        step();
        chk("bp_after_prd0", prd0_o, 34);

        do_reset();
        bun(1, 1, 5, 1, 2, 1, 6, 5, 3);
        step();
        repeat (4) begin
            bun(1, 1, 8, 5, 6, 1, 9, 8, 5);
            step();
        end
        rst_i = 1; free0_i = 1; free_preg0_i = 5;
        step();
        rst_i = 0; free0_i = 0;
        chk("mid_rst_valid", valid_o, 0); chk("mid_rst_prd0", prd0_o, 0);
        bun(1, 1, 10, 5, 0, 0, 0, 0, 0);
        step();
        chk("mid_rst_prs10", prs10_o, 5); chk("mid_rst_prd0_next", prd0_o, 32);

        do_reset();
        repeat (600) begin
            int idx;
            bun($urandom % 4 != 0, $urandom % 8 != 0, $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom % 8 != 0, $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 31));
            ready_i = $urandom % 4 != 0;
            free0_i = 0; free1_i = 0;
            if (pool.size() > 0 && $urandom % 2 == 0) begin
                idx = $urandom_range(0, pool.size() - 1);
                free0_i = 1; free_preg0_i = 6'(pool[idx]); pool.delete(idx);
            end else if ($urandom % 8 == 0) begin
                free0_i = 1; free_preg0_i = 0;
            end
            if (pool.size() > 0 && $urandom % 2 == 0) begin
                idx = $urandom_range(0, pool.size() - 1);
                free1_i = 1; free_preg1_i = 6'(pool[idx]); pool.delete(idx);
            end else if ($urandom % 8 == 0) begin
                free1_i = 1; free_preg1_i = 0;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
